// File: rtl/hazard_unit.sv
// Pipeline hazard control for the 5-stage RV32 core: stall/flush steering, EX operand forwarding,
// a data-memory wait watchdog and saturating performance counters.
module hazard_unit #(
  parameter logic [2:0] LOAD_SEL = 3'b001,
  parameter int         TIMEOUT  = 16,
  parameter int         CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       rs1_addr_d,
  input  logic [4:0]       rs2_addr_d,
  input  logic             rs1_used_d,
  input  logic             rs2_used_d,
  input  logic [4:0]       rs1_addr_ex,
  input  logic [4:0]       rs2_addr_ex,
  input  logic [4:0]       reg_dest_addr_ex,
  input  logic             reg_write_ex,
  input  logic [2:0]       result_mux_sel_ex,
  input  logic             pc_src_ex,
  input  logic [4:0]       reg_dest_addr_m,
  input  logic             reg_write_m,
  input  logic             dmem_req_m,
  input  logic             dmem_ready_i,
  input  logic [4:0]       reg_dest_addr_w,
  input  logic             reg_write_w,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_ex,
  output logic             flush_d,
  output logic             flush_ex,
  output logic [1:0]       fwd_a_sel_ex,
  output logic [1:0]       fwd_b_sel_ex,
  output logic             mem_timeout_o,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic [CNT_W-1:0] flush_count_o
);

  localparam int WC_W = $clog2(TIMEOUT + 1);

  typedef enum logic {
    ST_RUN,
    ST_MEM_WAIT
  } state_t;

  state_t            state_q, state_d;
  logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic              mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0]  flush_count_q, flush_count_d;

  logic mem_wait;
  logic load_use;
  logic redirect;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                          input logic wr_m, input logic [4:0] rd_m,
                                          input logic wr_w, input logic [4:0] rd_w);
    if (wr_m && (rd_m != 5'd0) && (rd_m == rs))      return 2'b10;
    else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) return 2'b01;
    else                                             return 2'b00;
  endfunction

  always_comb begin
    mem_wait = dmem_req_m & ~dmem_ready_i;
    load_use = reg_write_ex && (result_mux_sel_ex == LOAD_SEL) && (reg_dest_addr_ex != 5'd0) &&
               ((rs1_used_d && (rs1_addr_d == reg_dest_addr_ex)) ||
                (rs2_used_d && (rs2_addr_d == reg_dest_addr_ex)));
  end

  // Memory wait outranks a redirect so a resolved branch stays frozen in EX until the access ends.
  always_comb begin
    stall_f  = 1'b0;
    stall_d  = 1'b0;
    stall_ex = 1'b0;
    flush_d  = 1'b0;
    flush_ex = 1'b0;
    redirect = 1'b0;
    if (rst_i) begin
      flush_d  = 1'b1;
      flush_ex = 1'b1;
    end else if (mem_wait) begin
      stall_f  = 1'b1;
      stall_d  = 1'b1;
      stall_ex = 1'b1;
    end else if (pc_src_ex) begin
      flush_d  = 1'b1;
      flush_ex = 1'b1;
      redirect = 1'b1;
    end else if (load_use) begin
      stall_f  = 1'b1;
      stall_d  = 1'b1;
      flush_ex = 1'b1;
    end
  end

  always_comb begin
    fwd_a_sel_ex = 2'b00;
    fwd_b_sel_ex = 2'b00;
    if (!rst_i) begin
      fwd_a_sel_ex = fwd_sel(rs1_addr_ex, reg_write_m, reg_dest_addr_m, reg_write_w, reg_dest_addr_w);
      fwd_b_sel_ex = fwd_sel(rs2_addr_ex, reg_write_m, reg_dest_addr_m, reg_write_w, reg_dest_addr_w);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:      if (mem_wait)  state_d = ST_MEM_WAIT;
      ST_MEM_WAIT: if (!mem_wait) state_d = ST_RUN;
      default:     state_d = ST_RUN;
    endcase

    wait_cnt_d = '0;
    if (mem_wait) begin
      wait_cnt_d = (wait_cnt_q == WC_W'(TIMEOUT)) ? wait_cnt_q : wait_cnt_q + WC_W'(1);
    end
    mem_timeout_d = mem_timeout_q | (mem_wait && (wait_cnt_q == WC_W'(TIMEOUT - 1)));

    stall_cycles_d = stall_cycles_q;
    if (stall_f && !(&stall_cycles_q)) stall_cycles_d = stall_cycles_q + CNT_W'(1);
    flush_count_d = flush_count_q;
    if (redirect && !(&flush_count_q)) flush_count_d = flush_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= ST_RUN;
      wait_cnt_q     <= '0;
      mem_timeout_q  <= 1'b0;
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      mem_timeout_q  <= mem_timeout_d;
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign mem_timeout_o  = mem_timeout_q;
  assign stall_cycles_o = stall_cycles_q;
  assign flush_count_o  = flush_count_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed hazard scenarios plus random traffic, checked against a
// cycle-level reference model of the stall/flush/forward rules and the counters.
module tb_hazard_unit;
  localparam logic [2:0] LOAD_SEL = 3'b001;
  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk_i = 1'b0;
  logic rst_i;
  logic [4:0] rs1_addr_d, rs2_addr_d, rs1_addr_ex, rs2_addr_ex;
  logic rs1_used_d, rs2_used_d;
  logic [4:0] reg_dest_addr_ex, reg_dest_addr_m, reg_dest_addr_w;
  logic reg_write_ex, reg_write_m, reg_write_w;
  logic [2:0] result_mux_sel_ex;
  logic pc_src_ex, dmem_req_m, dmem_ready_i;
  logic stall_f, stall_d, stall_ex, flush_d, flush_ex, mem_timeout_o;
  logic [1:0] fwd_a_sel_ex, fwd_b_sel_ex;
  logic [CNT_W-1:0] stall_cycles_o, flush_count_o;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int m_run;
  int m_stall;
  int m_flush;
  bit m_timeout;

  always #5 clk_i = ~clk_i;

  hazard_unit #(.LOAD_SEL(LOAD_SEL), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .rs1_addr_d(rs1_addr_d), .rs2_addr_d(rs2_addr_d),
    .rs1_used_d(rs1_used_d), .rs2_used_d(rs2_used_d),
    .rs1_addr_ex(rs1_addr_ex), .rs2_addr_ex(rs2_addr_ex),
    .reg_dest_addr_ex(reg_dest_addr_ex), .reg_write_ex(reg_write_ex),
    .result_mux_sel_ex(result_mux_sel_ex), .pc_src_ex(pc_src_ex),
    .reg_dest_addr_m(reg_dest_addr_m), .reg_write_m(reg_write_m),
    .dmem_req_m(dmem_req_m), .dmem_ready_i(dmem_ready_i),
    .reg_dest_addr_w(reg_dest_addr_w), .reg_write_w(reg_write_w),
    .stall_f(stall_f), .stall_d(stall_d), .stall_ex(stall_ex),
    .flush_d(flush_d), .flush_ex(flush_ex),
    .fwd_a_sel_ex(fwd_a_sel_ex), .fwd_b_sel_ex(fwd_b_sel_ex),
    .mem_timeout_o(mem_timeout_o),
    .stall_cycles_o(stall_cycles_o), .flush_count_o(flush_count_o)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_fwd(input logic [4:0] rs);
    if (reg_write_m && reg_dest_addr_m != 0 && reg_dest_addr_m == rs) return 2;
    if (reg_write_w && reg_dest_addr_w != 0 && reg_dest_addr_w == rs) return 1;
    return 0;
  endfunction

  task automatic idle_inputs();
    rst_i = 0;
    rs1_addr_d = 0; rs2_addr_d = 0; rs1_used_d = 0; rs2_used_d = 0;
    rs1_addr_ex = 0; rs2_addr_ex = 0;
    reg_dest_addr_ex = 0; reg_write_ex = 0; result_mux_sel_ex = 0; pc_src_ex = 0;
    reg_dest_addr_m = 0; reg_write_m = 0; dmem_req_m = 0; dmem_ready_i = 0;
    reg_dest_addr_w = 0; reg_write_w = 0;
  endtask

  task automatic rand_inputs();
    rst_i = ($urandom_range(0, 59) == 0);
    rs1_addr_d = 5'($urandom_range(0, 3)); rs2_addr_d = 5'($urandom_range(0, 3));
    rs1_used_d = 1'($urandom); rs2_used_d = 1'($urandom);
    rs1_addr_ex = 5'($urandom_range(0, 3)); rs2_addr_ex = 5'($urandom_range(0, 3));
    reg_dest_addr_ex = 5'($urandom_range(0, 3)); reg_write_ex = 1'($urandom);
    result_mux_sel_ex = ($urandom_range(0, 1) == 0) ? LOAD_SEL : 3'($urandom);
    pc_src_ex = ($urandom_range(0, 3) == 0);
    reg_dest_addr_m = 5'($urandom_range(0, 3)); reg_write_m = 1'($urandom);
    dmem_req_m = 1'($urandom); dmem_ready_i = ($urandom_range(0, 2) == 0);
    reg_dest_addr_w = 5'($urandom_range(0, 3)); reg_write_w = 1'($urandom);
  endtask

  // Check all outputs against the model, advance one clock, update the model.
  task automatic step();
    bit w, lu, e_sf, e_sd, e_sx, e_fd, e_fx, redir;
    int e_fa, e_fb;
    #1;
    w  = dmem_req_m && !dmem_ready_i;
    lu = reg_write_ex && result_mux_sel_ex == LOAD_SEL && reg_dest_addr_ex != 0 &&
         ((rs1_used_d && rs1_addr_d == reg_dest_addr_ex) || (rs2_used_d && rs2_addr_d == reg_dest_addr_ex));
    {e_sf, e_sd, e_sx, e_fd, e_fx, redir} = '0;
    e_fa = 0; e_fb = 0;
    if (rst_i) begin
      e_fd = 1; e_fx = 1;
    end else begin
      e_fa = exp_fwd(rs1_addr_ex);
      e_fb = exp_fwd(rs2_addr_ex);
      if (w) begin
        e_sf = 1; e_sd = 1; e_sx = 1;
      end else if (pc_src_ex) begin
        e_fd = 1; e_fx = 1; redir = 1;
      end else if (lu) begin
        e_sf = 1; e_sd = 1; e_fx = 1;
      end
    end
    check_val("stall_f", 32'(stall_f), 32'(e_sf));
    check_val("stall_d", 32'(stall_d), 32'(e_sd));
    check_val("stall_ex", 32'(stall_ex), 32'(e_sx));
    check_val("flush_d", 32'(flush_d), 32'(e_fd));
    check_val("flush_ex", 32'(flush_ex), 32'(e_fx));
    check_val("fwd_a", 32'(fwd_a_sel_ex), e_fa);
    check_val("fwd_b", 32'(fwd_b_sel_ex), e_fb);
    check_val("timeout", 32'(mem_timeout_o), 32'(m_timeout));
    check_val("stall_cycles", 32'(stall_cycles_o), m_stall);
    check_val("flush_count", 32'(flush_count_o), m_flush);
    @(posedge clk_i);
    if (rst_i) begin
      m_run = 0; m_stall = 0; m_flush = 0; m_timeout = 0;
    end else begin
      m_run = w ? m_run + 1 : 0;
      if (m_run >= TIMEOUT) m_timeout = 1;
      if (e_sf && m_stall < CNT_MAX) m_stall++;
      if (redir && m_flush < CNT_MAX) m_flush++;
    end
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 1;
    step();
    rst_i = 0;
  endtask

  initial begin
    m_run = 0; m_stall = 0; m_flush = 0; m_timeout = 0;
    idle_inputs();
    rst_i = 1;
    @(negedge clk_i);
    step();
    step();
    check_val("rst_stall_cycles", 32'(stall_cycles_o), 0);
    check_val("rst_timeout", 32'(mem_timeout_o), 0);
    rst_i = 0;

    // load-use: load to x5 in EX, ID reads x5 via rs1
    reg_write_ex = 1; result_mux_sel_ex = LOAD_SEL; reg_dest_addr_ex = 5; rs1_used_d = 1; rs1_addr_d = 5;
    #1;
    check_val("lu_stall_f", 32'(stall_f), 1);
    check_val("lu_flush_ex", 32'(flush_ex), 1);
    check_val("lu_stall_ex", 32'(stall_ex), 0);
    step();
    idle_inputs();
    step();

    // forwarding priority and x0
    rs1_addr_ex = 7; reg_dest_addr_m = 7; reg_write_m = 1; reg_dest_addr_w = 7; reg_write_w = 1;
    #1; check_val("fwd_mem_wins", 32'(fwd_a_sel_ex), 2);
    step();
    reg_dest_addr_m = 0; reg_write_w = 0; rs1_addr_ex = 0;
    #1; check_val("fwd_x0", 32'(fwd_a_sel_ex), 0);
    step();
    rs1_addr_ex = 7; reg_write_m = 0; reg_write_w = 1;
    #1; check_val("fwd_wb", 32'(fwd_a_sel_ex), 1);
    step();
    idle_inputs();

    // redirect beats load-use
    do_reset();
    pc_src_ex = 1; reg_write_ex = 1; result_mux_sel_ex = LOAD_SEL; reg_dest_addr_ex = 3; rs2_used_d = 1; rs2_addr_d = 3;
    step();
    idle_inputs();
    check_val("redir_flush_count", 32'(flush_count_o), 1);
    check_val("redir_no_stall", 32'(stall_cycles_o), 0);

    // branch frozen by 3 wait cycles, redirect on 4th
    do_reset();
    pc_src_ex = 1; dmem_req_m = 1; dmem_ready_i = 0;
    repeat (3) step();
    check_val("bw_flush_count", 32'(flush_count_o), 0);
    check_val("bw_stall_cycles", 32'(stall_cycles_o), 3);
    dmem_ready_i = 1;
    step();
    check_val("bw_flush_after", 32'(flush_count_o), 1);
    idle_inputs();

    // watchdog with TIMEOUT=4
    do_reset();
    dmem_req_m = 1; dmem_ready_i = 0;
    repeat (3) step();
    check_val("wd_not_yet", 32'(mem_timeout_o), 0);
    step();
    check_val("wd_set", 32'(mem_timeout_o), 1);
    check_val("wd_stall_cycles", 32'(stall_cycles_o), 4);
    dmem_ready_i = 1;
    step();
    check_val("wd_sticky", 32'(mem_timeout_o), 1);

    // reset in the middle of a wait
    dmem_ready_i = 0;
    step(); step();
    rst_i = 1;
    step();
    rst_i = 0; dmem_req_m = 0;
    check_val("midrst_timeout", 32'(mem_timeout_o), 0);
    check_val("midrst_stall_cycles", 32'(stall_cycles_o), 0);
    step();

    // saturation: long stall run on a 4-bit counter
    dmem_req_m = 1; dmem_ready_i = 0;
    repeat (CNT_MAX + 3) step();
    check_val("sat_stall_cycles", 32'(stall_cycles_o), CNT_MAX);
    idle_inputs();
    pc_src_ex = 1;
    repeat (CNT_MAX + 3) step();
    check_val("sat_flush_count", 32'(flush_count_o), CNT_MAX);

    do_reset();
    repeat (3000) begin
      rand_inputs();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
